// File: rtl/player_mover.sv
// player_mover: 8-way player sprite controller with playfield clamping and a registered pixel hit flag.
// Optional PLAYER_ACCEL_EN doubles the step once the same motion has held for 8 consecutive ticks.
module player_mover #(
  parameter int SIZE   = 15,
  parameter int STEP   = 4,
  parameter int X_INIT = 30,
  parameter int Y_INIT = 449,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 639,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 479
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  output logic       playa,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [3:0] dir,
  output logic       moving
);
  typedef enum logic [3:0] {
    STOP = 4'd0, UP = 4'd1, DOWN = 4'd2, LEFT = 4'd3, RIGHT = 4'd4,
    UR = 4'd5, UL = 4'd6, DR = 4'd7, DL = 4'd8
  } state_t;
  localparam logic signed [10:0] XLO = 11'(X_MIN);
  localparam logic signed [10:0] XHI = 11'(X_MAX - SIZE + 1);
  localparam logic signed [10:0] YLO = 11'(Y_MIN);
  localparam logic signed [10:0] YHI = 11'(Y_MAX - SIZE + 1);
  localparam logic signed [10:0] ST  = 11'(STEP);
  state_t r_dir, w_dir_nxt;
  logic r_moving, r_playa;
  logic [9:0] r_x, r_y;
  logic w_v_up, w_v_dn, w_h_l, w_h_r;
  logic w_xl, w_xr, w_yu, w_yd;
  logic signed [10:0] w_step, w_xs, w_ys, w_xc, w_yc;
  // Pressing both buttons of a pair cancels that axis.
  assign w_v_up = !up && down;
  assign w_v_dn = !down && up;
  assign w_h_l  = !left && right;
  assign w_h_r  = !right && left;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir    <= STOP;
      r_moving <= 1'b0;
    end else if (update) begin
      r_dir    <= w_dir_nxt;
      r_moving <= w_dir_nxt != STOP;
    end
  end
  always_comb begin
    w_dir_nxt = r_dir;
    if (update)
      case ({w_v_up, w_v_dn, w_h_l, w_h_r})
        4'b1000: w_dir_nxt = UP;
        4'b0100: w_dir_nxt = DOWN;
        4'b0010: w_dir_nxt = LEFT;
        4'b0001: w_dir_nxt = RIGHT;
        4'b1001: w_dir_nxt = UR;
        4'b1010: w_dir_nxt = UL;
        4'b0101: w_dir_nxt = DR;
        4'b0110: w_dir_nxt = DL;
        default: w_dir_nxt = STOP;
      endcase
  end
  always_comb begin
    w_xl = r_dir == LEFT  || r_dir == UL || r_dir == DL;
    w_xr = r_dir == RIGHT || r_dir == UR || r_dir == DR;
    w_yu = r_dir == UP    || r_dir == UR || r_dir == UL;
    w_yd = r_dir == DOWN  || r_dir == DR || r_dir == DL;
  end
`ifdef PLAYER_ACCEL_EN
  logic [3:0] r_run;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 4'd0;
    else if (update)
      r_run <= (w_dir_nxt == r_dir && r_dir != STOP) ? (r_run == 4'd8 ? 4'd8 : r_run + 4'd1) : 4'd0;
  end
  assign w_step = (r_run == 4'd8) ? ST <<< 1 : ST;
`else
  assign w_step = ST;
`endif
  // Signed 11-bit sums let an underflow past zero be clamped rather than wrap.
  always_comb begin
    w_xs = $signed({1'b0, r_x}) + (w_xr ? w_step : w_xl ? -w_step : 11'sd0);
    w_ys = $signed({1'b0, r_y}) + (w_yd ? w_step : w_yu ? -w_step : 11'sd0);
    w_xc = w_xs < XLO ? XLO : w_xs > XHI ? XHI : w_xs;
    w_yc = w_ys < YLO ? YLO : w_ys > YHI ? YHI : w_ys;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= 10'(X_INIT);
      r_y <= 10'(Y_INIT);
    end else if (update) begin
      r_x <= w_xc[9:0];
      r_y <= w_yc[9:0];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_playa <= 1'b0;
    else r_playa <= ({1'b0, xCount} >= {1'b0, r_x}) && ({1'b0, xCount} < {1'b0, r_x} + 11'(SIZE)) &&
                    ({1'b0, yCount} >= {1'b0, r_y}) && ({1'b0, yCount} < {1'b0, r_y} + 11'(SIZE));
  end
  assign playa  = r_playa;
  assign x_pos  = r_x;
  assign y_pos  = r_y;
  assign dir    = r_dir;
  assign moving = r_moving;
endmodule
